receiver_block: RTL
===================

RECEIVER_BLOCK -- requirements
Module: receiver_block

Interface
REQ-001 clk_i  in  1  system clock; all logic on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-high.
REQ-003 cmp_en_i  in  1  push strobe: one expected transaction to check.
REQ-004 cmp_struct_i  in  cmp_struct_t  fields: start_addr, data_mode, data_ptrn, start_off, end_off, words_count (beats-1); sampled when cmp_en_i=1.
REQ-005 readdatavalid_i  in  1  AMM read-response beat valid.
REQ-006 readdata_i  in  AMM_DATA_W  AMM read-response data.
REQ-007 err_clr_i  in  1  clears sticky error state.
REQ-008 cmp_error_o  out  1  one-cycle pulse on first detected error.
REQ-009 err_flag_o  out  1  sticky error indicator.
REQ-010 err_addr_o  out  ADDR_W  word address of the first failing beat: start_addr + beat index.
REQ-011 err_data_o  out  AMM_DATA_W  readdata of the first failing beat.
REQ-012 err_type_o  out  2  0=data mismatch, 1=unexpected beat, 2=queue overflow.
REQ-013 pend_cnt_o  out  3  number of queued expected transactions (0..4).
REQ-014 beat_cnt_o  out  32  total readdatavalid beats received; wraps at 2^32.

Function
REQ-015 Pending queue SHALL hold 4 cmp_struct_t entries, FIFO order; a cmp_en_i push is visible at the head from the next cycle.
REQ-016 Push on full queue SHALL be discarded and raise error type 2, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-017 Every readdatavalid_i beat is checked against the head entry; beat index b runs 0..words_count.
REQ-018 On the beat where b==words_count, the head SHALL pop and b SHALL return to 0.
REQ-019 Expected byte = data_ptrn for FIX data_mode; for RND_DATA, byte = 8-bit LFSR seeded with data_ptrn at beat 0, advanced once per beat: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-020 Expected word = expected byte replicated DATA_B_W times.
REQ-021 Byte mask (ADDR_TYPE "BYTE"): beat 0 checks bytes >= start_off; beat words_count checks bytes <= end_off; single beat checks start_off..end_off; middle beats check all bytes; ADDR_TYPE "WORD": all bytes always.
REQ-022 Mismatch on any enabled byte SHALL be error type 0.
REQ-023 readdatavalid_i with an empty queue SHALL be error type 1; the beat is dropped and no LFSR or queue state changes.
REQ-024 Compare is registered: cmp_error_o pulses exactly 1 cycle after the failing beat; err_* outputs update in the same cycle.
REQ-025 err_addr_o, err_data_o, err_type_o SHALL capture only while err_flag_o=0; later errors do not pulse cmp_error_o or overwrite them.
REQ-026 err_clr_i SHALL clear err_flag_o next cycle; if an error is detected in the same cycle, the error SHALL win.
REQ-027 Checking continues after an error; the queue is not flushed by an error.
REQ-028 beat_cnt_o SHALL increment on every readdatavalid_i, including unexpected beats.

Reset
REQ-029 rst_i SHALL give: queue empty, b=0, LFSR=data-invalid, cmp_error_o=0, err_flag_o=0, err_addr_o=0, err_data_o=0, err_type_o=0, pend_cnt_o=0, beat_cnt_o=0.
REQ-030 Reset mid-burst SHALL discard all pending entries; beats after reset release with an empty queue are type 1 errors.

Structure
REQ-031 cmp_struct_t, data_mode_t (FIX_DATA, RND_DATA), the LFSR next-state function, and CMP_FIFO_DEPTH=4 SHALL reside in rtl_settings_pkg.
REQ-032 The pending queue SHALL be a sub-module, cmp_fifo, a synchronous FIFO parameterised by width and depth.

Verification
REQ-033 FIX, ptrn 0xA5, words_count=3, 4 beats all 0xA5 -> no error; pend_cnt 1->0; beat_cnt=4.
REQ-034 RND, seed 0xFF, 2 beats; beat1 expected byte 0xFE; inject 0xFF on beat1 -> cmp_error_o pulse 1 cycle later, err_type=0, err_addr=start_addr+1.
REQ-035 BYTE mode, DATA_B_W=4, start_off=2, end_off=1, words_count=1; beat0 bytes0-1 corrupted, beat1 bytes2-3 corrupted -> no error.
REQ-036 readdatavalid_i with empty queue -> err_type=1; following valid transaction passes; beat_cnt counts both.
REQ-037 5 pushes with no beats -> 5th gives err_type=2, pend_cnt=4; push on full with a same-cycle final beat -> accepted, pend_cnt stays 4.
REQ-038 Assert rst_i during beat 2 of a 4-beat burst -> all outputs 0; next beat -> err_type=1.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared settings for the read-response checker: bus widths, the expected-transaction
// descriptor, and the pattern LFSR used for pseudo-random data.
package rtl_settings_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned AMM_DATA_W     = 32;
  localparam int unsigned DATA_B_W       = AMM_DATA_W / 8;
  localparam int unsigned OFF_W          = $clog2(DATA_B_W);
  localparam int unsigned WC_W           = 8;
  localparam int unsigned CMP_FIFO_DEPTH = 4;
  localparam int unsigned PEND_W         = $clog2(CMP_FIFO_DEPTH + 1);

  typedef enum logic {
    WORD_ADDR,
    BYTE_ADDR
  } addr_type_t;

  localparam addr_type_t ADDR_TYPE = BYTE_ADDR;

  typedef enum logic {
    FIX_DATA,
    RND_DATA
  } data_mode_t;

  typedef enum logic [1:0] {
    ErrData  = 2'd0,
    ErrUnexp = 2'd1,
    ErrOvf   = 2'd2
  } err_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0] start_addr;
    data_mode_t        data_mode;
    logic [7:0]        data_ptrn;
    logic [OFF_W-1:0]  start_off;
    logic [OFF_W-1:0]  end_off;
    logic [WC_W-1:0]   words_count;  // beats - 1
  } cmp_struct_t;

  function automatic logic [7:0] lfsr_next(logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/receiver_block_if.sv
// Expected-transaction push, read-response beats and error reporting of receiver_block.
interface receiver_block_if;
  import rtl_settings_pkg::*;

  logic                  cmp_en_i;
  cmp_struct_t           cmp_struct_i;
  logic                  readdatavalid_i;
  logic [AMM_DATA_W-1:0] readdata_i;
  logic                  err_clr_i;

  logic                  cmp_error_o;
  logic                  err_flag_o;
  logic [ADDR_W-1:0]     err_addr_o;
  logic [AMM_DATA_W-1:0] err_data_o;
  logic [1:0]            err_type_o;
  logic [PEND_W-1:0]     pend_cnt_o;
  logic [31:0]           beat_cnt_o;

  modport master (
    output cmp_en_i, cmp_struct_i, readdatavalid_i, readdata_i, err_clr_i,
    input  cmp_error_o, err_flag_o, err_addr_o, err_data_o, err_type_o, pend_cnt_o, beat_cnt_o
  );

  modport slave (
    input  cmp_en_i, cmp_struct_i, readdatavalid_i, readdata_i, err_clr_i,
    output cmp_error_o, err_flag_o, err_addr_o, err_data_o, err_type_o, pend_cnt_o, beat_cnt_o
  );

endinterface

// File: rtl/cmp_fifo.sv
// Synchronous FIFO holding pending expected transactions; a push may land on a full
// FIFO when a pop happens in the same cycle.
module cmp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             wdata_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/receiver_block.sv
// Checks read-response beats against queued expected transactions and records the
// first failure in a sticky error report.
module receiver_block
  import rtl_settings_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  receiver_block_if.slave bus_io
);

  cmp_struct_t                   head;
  logic [$bits(cmp_struct_t)-1:0] fifo_rdata;
  logic                          fifo_full, fifo_empty;
  logic [PEND_W-1:0]             fifo_count;

  logic [WC_W-1:0]       beat_idx_q, beat_idx_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic                  cmp_error_q, cmp_error_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [AMM_DATA_W-1:0] err_data_q, err_data_d;
  err_type_t             err_type_q, err_type_d;

  logic             beat_valid, last_beat, pop;
  logic [7:0]       exp_byte;
  logic [OFF_W-1:0] lo_byte, hi_byte;
  logic             mismatch;
  logic             data_err, unexp_err, ovf_err, err_det;

  cmp_fifo #(
    .Width ($bits(cmp_struct_t)),
    .Depth (CMP_FIFO_DEPTH)
  ) u_cmp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus_io.cmp_en_i),
    .pop_i   (pop),
    .wdata_i (bus_io.cmp_struct_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head       = cmp_struct_t'(fifo_rdata);
  assign beat_valid = bus_io.readdatavalid_i && !fifo_empty;
  assign last_beat  = (beat_idx_q == head.words_count);
  assign pop        = beat_valid && last_beat;

  // Beat 0 always uses the seed; later RND beats use the advanced LFSR.
  assign exp_byte = (head.data_mode == RND_DATA && beat_idx_q != '0) ? lfsr_q : head.data_ptrn;

  always_comb begin
    lo_byte = '0;
    hi_byte = OFF_W'(DATA_B_W - 1);
    if (ADDR_TYPE == BYTE_ADDR) begin
      if (beat_idx_q == '0) lo_byte = head.start_off;
      if (last_beat)        hi_byte = head.end_off;
    end
    mismatch = 1'b0;
    for (int i = 0; i < DATA_B_W; i++) begin
      if (OFF_W'(i) >= lo_byte && OFF_W'(i) <= hi_byte &&
          bus_io.readdata_i[8*i +: 8] != exp_byte) begin
        mismatch = 1'b1;
      end
    end
  end

  assign data_err  = beat_valid && mismatch;
  assign unexp_err = bus_io.readdatavalid_i && fifo_empty;
  assign ovf_err   = bus_io.cmp_en_i && fifo_full && !pop;
  assign err_det   = data_err || unexp_err || ovf_err;

  always_comb begin
    beat_idx_d = beat_idx_q;
    lfsr_d     = lfsr_q;
    beat_cnt_d = beat_cnt_q;
    if (bus_io.readdatavalid_i) beat_cnt_d = beat_cnt_q + 32'd1;
    if (beat_valid) begin
      lfsr_d     = lfsr_next(exp_byte);
      beat_idx_d = last_beat ? '0 : beat_idx_q + WC_W'(1);
    end
  end

  always_comb begin
    cmp_error_d = 1'b0;
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    err_type_d  = err_type_q;
    if (bus_io.err_clr_i) err_flag_d = 1'b0;
    if (err_det) begin
      err_flag_d = 1'b1;
      // Only the first error since the last clear is reported.
      if (!err_flag_q) begin
        cmp_error_d = 1'b1;
        if (data_err) begin
          err_type_d = ErrData;
          err_addr_d = head.start_addr + ADDR_W'(beat_idx_q);
          err_data_d = bus_io.readdata_i;
        end else if (unexp_err) begin
          err_type_d = ErrUnexp;
          err_addr_d = '0;
          err_data_d = bus_io.readdata_i;
        end else begin
          err_type_d = ErrOvf;
          err_addr_d = bus_io.cmp_struct_i.start_addr;
          err_data_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_idx_q  <= '0;
      lfsr_q      <= '0;
      beat_cnt_q  <= '0;
      cmp_error_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      err_type_q  <= ErrData;
    end else begin
      beat_idx_q  <= beat_idx_d;
      lfsr_q      <= lfsr_d;
      beat_cnt_q  <= beat_cnt_d;
      cmp_error_q <= cmp_error_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      err_type_q  <= err_type_d;
    end
  end

  assign bus_io.cmp_error_o = cmp_error_q;
  assign bus_io.err_flag_o  = err_flag_q;
  assign bus_io.err_addr_o  = err_addr_q;
  assign bus_io.err_data_o  = err_data_q;
  assign bus_io.err_type_o  = err_type_q;
  assign bus_io.pend_cnt_o  = fifo_count;
  assign bus_io.beat_cnt_o  = beat_cnt_q;

endmodule
